// File: rtl/drone_cmd_sequencer_pkg.sv
// Shared types and constants for the drone command sequencer.
package drone_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SETTLE,
    CHECK,
    GAP,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [2:0] alt;
    logic [2:0] dir0;
    logic [2:0] dir1;
  } cmd_t;

  localparam int unsigned MOT_L   = 0;
  localparam int unsigned MOT_RT  = 1;
  localparam int unsigned MOT_F   = 2;
  localparam int unsigned MOT_RV  = 3;
  localparam int unsigned NUM_MOT = 4;

  localparam logic [2:0] HOVER_CMD = 3'b000;

  // Command word layout: [8:6]=alt, [5:3]=dir0, [2:0]=dir1.
  function automatic cmd_t unpack_cmd(input logic [11:0] w);
    return cmd_t'(w[8:0]);
  endfunction

  // Target word holds motor L in the top 16 bits down to Rv in the bottom.
  function automatic logic [15:0] tgt_field(input logic [63:0] w, input int unsigned m);
    return w[(MOT_RV - m)*16 +: 16];
  endfunction

endpackage

// File: rtl/drone_cmd_sequencer_rpm_window_check.sv
// Signed window compare of one motor rpm against its target.
module rpm_window_check #(
  parameter int unsigned WINDOW = 6
) (
  input  logic [15:0] i_rpm,
  input  logic [15:0] i_tgt,
  output logic        o_fail
);

  localparam logic signed [16:0] W_POS = 17'(WINDOW);
  localparam logic signed [16:0] W_NEG = -W_POS;

  logic signed [16:0] w_diff;

  // 17-bit sign-extended difference cannot wrap; |d| == WINDOW passes.
  always_comb begin
    w_diff = $signed({i_rpm[15], i_rpm}) - $signed({i_tgt[15], i_tgt});
    o_fail = (w_diff > W_POS) || (w_diff < W_NEG);
  end

endmodule

// File: rtl/drone_cmd_sequencer.sv
// Command master: plays LENMEM command/target entries from a sync-read ROM,
// holds each for a dwell, checks the four motor rpm values at dwell end.
// Build option: DRONE_SEQ_ABORT_EN -- first failing check ends the script.
module drone_cmd_sequencer
  import drone_seq_pkg::*;
#(
  parameter int unsigned LENMEM     = 106,
  parameter int unsigned WINDOW     = 6,
  parameter int unsigned SETTLE_CYC = 50,
  parameter int unsigned GAP_CYC    = 24,
  localparam int unsigned AW = (LENMEM > 1) ? $clog2(LENMEM) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [AW-1:0]        rom_addr,
  input  logic [11:0]          cmd_word,
  input  logic [63:0]          tgt_word,
  output logic [2:0]           altcmd,
  output logic [1:0][2:0]      dircmd,
  input  logic [3:0][15:0]     rpm_sense,
  output logic                 busy,
  output logic                 done,
  output logic                 fail_valid,
  output logic [3:0]           fail_mask,
  output logic [AW-1:0]        fail_idx,
  output logic [15:0]          err_count
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
  localparam logic [AW-1:0] LAST_IDX    = AW'(LENMEM - 1);

  seq_state_e          r_state;
  seq_state_e          w_next;
  logic [AW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [3:0][15:0]    r_tgt;
  cmd_t                r_cmd;
  logic                r_fail_valid;
  logic [3:0]          r_fail_mask;
  logic [AW-1:0]       r_fail_idx;
  logic [15:0]         r_err;
  logic [3:0]          w_fail;
  logic                w_any_fail;
  logic                w_start_ok;
  logic                w_unused_bits;

  assign w_unused_bits = ^cmd_word[11:9];

  // One window checker per motor.
  for (genvar g = 0; g < NUM_MOT; g++) begin : g_mot
    rpm_window_check #(.WINDOW(WINDOW)) u_chk (
      .i_rpm  (rpm_sense[g]),
      .i_tgt  (r_tgt[g]),
      .o_fail (w_fail[g])
    );
  end

  assign w_any_fail = |w_fail;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE:   if (start) w_next = FETCH;
      FETCH:  begin busy = 1'b1; w_next = LOAD; end
      LOAD:   begin busy = 1'b1; w_next = SETTLE; end
      SETTLE: begin
        busy = 1'b1;
        if (r_cnt == SETTLE_LAST) w_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
`ifdef DRONE_SEQ_ABORT_EN
        w_next = w_any_fail ? DONE : GAP;
`else
        w_next = GAP;
`endif
      end
      GAP: begin
        busy = 1'b1;
        if (r_cnt == GAP_LAST) w_next = (r_idx == LAST_IDX) ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: entry index, dwell counter, command/target latches, fail log.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tgt        <= '0;
      r_cmd        <= '{alt: HOVER_CMD, dir0: HOVER_CMD, dir1: HOVER_CMD};
      r_fail_valid <= 1'b0;
      r_fail_mask  <= '0;
      r_fail_idx   <= '0;
      r_err        <= '0;
    end else begin
      r_fail_valid <= 1'b0;
      if (w_start_ok) begin
        r_idx <= '0;
        r_err <= '0;
      end
      case (r_state)
        LOAD: begin
          r_cmd <= unpack_cmd(cmd_word);
          for (int unsigned m = 0; m < NUM_MOT; m++) r_tgt[m] <= tgt_field(tgt_word, m);
          r_cnt <= '0;
        end
        SETTLE: r_cnt <= (r_cnt == SETTLE_LAST) ? '0 : r_cnt + 1'b1;
        CHECK: begin
          if (w_any_fail) begin
            r_fail_valid <= 1'b1;
            r_fail_mask  <= w_fail;
            r_fail_idx   <= r_idx;
            if (r_err != '1) r_err <= r_err + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Entering DONE (normal end or abort) returns the commands to hover.
      if (w_next == DONE) r_cmd <= '{alt: HOVER_CMD, dir0: HOVER_CMD, dir1: HOVER_CMD};
    end
  end

  assign rom_addr   = r_idx;
  assign altcmd     = r_cmd.alt;
  assign dircmd[0]  = r_cmd.dir0;
  assign dircmd[1]  = r_cmd.dir1;
  assign fail_valid = r_fail_valid;
  assign fail_mask  = r_fail_mask;
  assign fail_idx   = r_fail_idx;
  assign err_count  = r_err;

endmodule

// File: tb/tb_drone_cmd_sequencer.sv
// Self-checking bench for drone_cmd_sequencer (4-entry script).
module tb_drone_cmd_sequencer;

  localparam int N    = 4;
  localparam int WIN  = 6;
  localparam int SET  = 50;
  localparam int GAPC = 24;
  localparam int PER  = 3 + SET + GAPC;
  localparam int FV   = SET + 3;
`ifdef DRONE_SEQ_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        rom_addr;
  logic [11:0]       cmd_word;
  logic [63:0]       tgt_word;
  logic [2:0]        altcmd;
  logic [1:0][2:0]   dircmd;
  logic [3:0][15:0]  rpm_sense;
  logic              busy, done, fail_valid;
  logic [3:0]        fail_mask;
  logic [1:0]        fail_idx;
  logic [15:0]       err_count;

  logic [11:0]       cmd_tb [N];
  logic [3:0][15:0]  tgt_tb [N];
  logic [3:0][15:0]  rpm_tb [N];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0;
  bit trk = 1'b0;
  int busy_cnt, nlog, max_addr;
  logic [3:0] log_mask [8];
  logic [1:0] log_idx  [8];

  always #5 clk = ~clk;

  drone_cmd_sequencer #(
    .LENMEM(N), .WINDOW(WIN), .SETTLE_CYC(SET), .GAP_CYC(GAPC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
    .cmd_word(cmd_word), .tgt_word(tgt_word), .altcmd(altcmd), .dircmd(dircmd),
    .rpm_sense(rpm_sense), .busy(busy), .done(done), .fail_valid(fail_valid),
    .fail_mask(fail_mask), .fail_idx(fail_idx), .err_count(err_count)
  );

  // Sync-read ROM and a plant whose rpm follows the current entry.
  always @(posedge clk) begin
    cmd_word <= cmd_tb[rom_addr];
    tgt_word <= {tgt_tb[rom_addr][0], tgt_tb[rom_addr][1], tgt_tb[rom_addr][2], tgt_tb[rom_addr][3]};
  end
  assign rpm_sense = rpm_tb[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] exp_mask(input int e);
    logic [3:0] mk;
    int d;
    mk = '0;
    for (int m = 0; m < 4; m++) begin
      d = int'($signed(rpm_tb[e][m])) - int'($signed(tgt_tb[e][m]));
      if (d > WIN || d < -WIN) mk[m] = 1'b1;
    end
    return mk;
  endfunction

  function automatic int first_fail();
    for (int e = 0; e < N; e++) if (exp_mask(e) != 4'b0) return e;
    return N;
  endfunction

  function automatic int fails_before(input int e);
    int c;
    c = 0;
    for (int k = 0; k < e; k++) if (exp_mask(k) != 4'b0) c++;
    return c;
  endfunction

  function automatic int end_time();
    int ef;
    ef = first_fail();
    if (ABORT && ef < N) return ef * PER + FV;
    return N * PER;
  endfunction

  // Per-cycle expectations derived from the entry timeline since start.
  task automatic check_cycle(input int t);
    int ef, et, e, p, exp_addr, exp_err, fv_e;
    logic [11:0] c;
    logic exp_busy, exp_done, exp_fv;
    ef = first_fail();
    et = end_time();
    fv_e = 0;
    if (t < et) begin
      e = t / PER;
      p = t % PER;
      exp_busy = 1'b1;
      exp_done = 1'b0;
      exp_addr = e;
      if (p >= 2)      c = cmd_tb[e];
      else if (e == 0) c = '0;
      else             c = cmd_tb[e-1];
      exp_fv  = (p == FV) && (exp_mask(e) != 4'b0);
      exp_err = fails_before(e) + (((p >= FV) && (exp_mask(e) != 4'b0)) ? 1 : 0);
      fv_e    = e;
    end else begin
      exp_busy = 1'b0;
      exp_done = 1'b1;
      c        = '0;
      exp_addr = (ABORT && ef < N) ? ef : N - 1;
      exp_fv   = ABORT && (ef < N) && (t == et);
      exp_err  = (ABORT && ef < N) ? 1 : fails_before(N);
      fv_e     = (ef < N) ? ef : 0;
    end
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("rom_addr", rom_addr, exp_addr);
    chk("altcmd", altcmd, c[8:6]);
    chk("dircmd0", dircmd[0], c[5:3]);
    chk("dircmd1", dircmd[1], c[2:0]);
    chk("fail_valid", fail_valid, exp_fv);
    chk("err_count", err_count, exp_err);
    if (exp_fv) begin
      chk("fail_mask", fail_mask, exp_mask(fv_e));
      chk("fail_idx", fail_idx, fv_e);
    end
  endtask

  always @(negedge clk) begin
    if (trk) begin
      check_cycle(cyc - start_cyc - 1);
      if (busy) busy_cnt++;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (fail_valid) begin
        if (nlog < 8) begin
          log_mask[nlog] = fail_mask;
          log_idx[nlog]  = fail_idx;
        end
        nlog++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_run();
    busy_cnt = 0;
    nlog     = 0;
    max_addr = 0;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    trk   = 1'b1;
  endtask

  task automatic run_script(input int spurious_at);
    int len;
    len = end_time() + 4;
    begin_run();
    for (int k = 0; k < len; k++) begin
      start = (k == spurious_at);
      tick();
    end
    start = 1'b0;
    trk   = 1'b0;
  endtask

  task automatic load_happy();
    for (int e = 0; e < N; e++) begin
      cmd_tb[e] = {3'b101, 3'(e + 1), 3'(e + 2), 3'(7 - e)};
      for (int m = 0; m < 4; m++) begin
        tgt_tb[e][m] = 16'(1000 * (e + 1) + 10 * m);
        rpm_tb[e][m] = 16'(1000 * (e + 1) + 10 * m);
      end
    end
  endtask

  task automatic load_edges();
    for (int e = 0; e < N; e++) cmd_tb[e] = {3'b000, 3'(7 - e), 3'(e + 3), 3'(e)};
    tgt_tb[0] = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    rpm_tb[0] = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    // index order in the literal is [3]=Rv,[2]=F,[1]=Rt,[0]=L
    tgt_tb[1] = {16'h2222, 16'h1000, 16'h1000, 16'h1000};
    rpm_tb[1] = {16'h2222, 16'h0FFA, 16'h1006, 16'h1007};
    tgt_tb[2] = {16'h0000, 16'h0123, 16'h0042, 16'h0000};
    rpm_tb[2] = {16'hFFF9, 16'h0123, 16'h0042, 16'hFFFA};
    tgt_tb[3] = {16'h0055, 16'h7FFF, 16'h8000, 16'h8006};
    rpm_tb[3] = {16'h0055, 16'h8000, 16'h7FFF, 16'h8000};
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_happy();
    repeat (3) tick();
    chk("rst_altcmd", altcmd, 3'b000);
    chk("rst_dircmd", dircmd, 6'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_count, 16'd0);
    chk("rst_fv", fail_valid, 1'b0);
    chk("rst_addr", rom_addr, 2'd0);
    reset = 1'b0;
    tick();

    // Happy path with a start pulse mid-script that must be ignored.
    run_script(100);
    chk("happy_busy_cycles", busy_cnt, 308);
    chk("happy_nfail", nlog, 0);
    chk("happy_done", done, 1'b1);

    // Window / signed edges, restarted from DONE.
    load_edges();
    run_script(-1);
`ifdef DRONE_SEQ_ABORT_EN
    chk("edge_busy_cycles", busy_cnt, 130);
    chk("edge_nfail", nlog, 1);
    chk("edge_err_final", err_count, 16'd1);
    chk("edge_max_addr", max_addr, 1);
    chk("edge_mask0", log_mask[0], 4'b0001);
    chk("edge_idx0", log_idx[0], 2'd1);
`else
    chk("edge_busy_cycles", busy_cnt, 308);
    chk("edge_nfail", nlog, 3);
    chk("edge_err_final", err_count, 16'd3);
    chk("edge_max_addr", max_addr, 3);
    chk("edge_mask0", log_mask[0], 4'b0001);
    chk("edge_idx0", log_idx[0], 2'd1);
    chk("edge_mask1", log_mask[1], 4'b1000);
    chk("edge_idx1", log_idx[1], 2'd2);
    chk("edge_mask2", log_mask[2], 4'b0110);
    chk("edge_idx2", log_idx[2], 2'd3);
`endif

    // Reset in the middle of entry 2's settle window.
    load_happy();
    begin_run();
    repeat (2 * PER + 10) tick();
    trk   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_altcmd", altcmd, 3'b000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", rom_addr, 2'd0);
    tick();
    @(negedge clk);
    chk("midrst_dircmd", dircmd, 6'b0);
    chk("midrst_done", done, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    run_script(-1);
    chk("after_rst_busy_cycles", busy_cnt, 308);
    chk("after_rst_err", err_count, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
